muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for RV64M multiply/divide operations in the execute stage. It accepts one operation from execute, holds the pipeline stalled while it iterates, and returns a 64-bit result on a one-cycle `done` pulse. Execute muxes `result` in place of the ALU output during that cycle. There is one operation in flight at most. Multiply uses a registered full product; divide is radix-2 restoring, one quotient bit per cycle.

## Interface
- No parameters. The width is fixed at 64 bits (`word_t`).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request from execute; `dataD.valid` qualified with the M-op decode.
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `word`  in  1  selects a *W variant (MULW, DIVW, DIVUW, REMW, REMUW).
- `a`, `b`  in  64 each  forwarded operands, post-forwarding-mux `src1_reg` and `src2_reg`.
- `flush`  in  1  abort from a branch or trap redirect.
- `stall`  out  1  holds IF, ID and EX.
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  64  product or quotient/remainder; held until the next `done`.

## Operation
- States and transitions:
  - IDLE: go to MUL or DIV on start.
  - MUL: go to DONE.
  - DIV: stay for K cycles, then go to FIX.
  - FIX: go to DONE.
  - DONE: go to IDLE.
- IDLE with `start` and not `flush`:
  - Latch `op`, `word`, `a` and `b`.
  - Clear the iteration counter.
  - Enter MUL for op[2]=0, otherwise DIV.
- `start` in any non-IDLE state is ignored. Upstream holds its inputs because `stall` is high.
- Operand preparation when `word`=1:
  - Truncate to bits 31:0.
  - Sign-extend for the signed ops (MUL, DIV, REM); zero-extend for DIVU and REMU.
  - K=32 for word ops, K=64 otherwise.
- MUL state: compute the 128-bit product with signedness per op.
  - MUL takes bits 63:0.
  - MULH, MULHSU and MULHU take bits 127:64.
  - MULW takes bits 31:0 sign-extended to 64.
- DIV state: operate on magnitudes for signed ops. Each cycle shifts in one dividend bit and conditionally subtracts the divisor.
- FIX state applies sign correction:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Word results are sign-extended from bit 31.
- Special cases:
  - Divisor 0: quotient = all ones (W: 0xFFFFFFFFFFFFFFFF) and remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow (most-negative / -1): quotient = dividend and remainder = 0.
- `flush` in any state:
  - Next state is IDLE, with no `done`; `result` keeps its old value.
  - `flush` with `start` in the same cycle causes the start to be discarded.
- `stall` = (`start` & IDLE & !`flush`) | (`busy` & state!=DONE & !`flush`).

## Timing
- Reset values: state IDLE, `stall`=0, `busy`=0, `done`=0, `result`=0, counter=0.
- Start is accepted in cycle N. `stall` is high combinationally in cycle N.
- Multiply: MUL in N+1, DONE in N+2. Latency is 2 cycles.
- Divide: DIV in N+1..N+K, FIX in N+K+1, DONE in N+K+2. Latency is 66 cycles (doubleword) or 34 (word).
- In the DONE cycle, `stall`=0 and `done`=1, so execute advances with `result` that same cycle.
- A new `start` is accepted earliest in the cycle after DONE, since DONE returns to IDLE.
- `reset` overrides `flush` and `start`.

## Configuration
- `MDU_FASTDIV_EN` defined:
  - Divide-by-zero and signed-overflow go IDLE -> FIX -> DONE, for 2-cycle latency.
  - Divisor magnitude 1 also takes the fast path.
- `MDU_FASTDIV_EN` undefined: every divide runs the full K iterations. The special-case values come out of the FIX fixup, with results identical.

## Test plan
- MUL with a=7, b=-3 (0xFFFFFFFFFFFFFFFD): start in N -> `done` in N+2 with `result`=0xFFFFFFFFFFFFFFEB; `stall` high in N and N+1, low in N+2.
- MULHU with a=b=0xFFFFFFFFFFFFFFFF -> `result`=0xFFFFFFFFFFFFFFFE. MULW with 0x80000000 x 2 -> 0x0000000000000000.
- DIVU 100/7 -> 14 with `done` at N+66. REM -7 % 2 -> 0xFFFFFFFFFFFFFFFF. REMUW 0x1_00000005 % 3 -> 2 with `done` at N+34.
- DIV 5/0 -> 0xFFFFFFFFFFFFFFFF and REMU 5/0 -> 5. DIVW 0x80000000 / -1 -> 0xFFFFFFFF80000000 and REMW -> 0. Latency is N+66/N+34 without `MDU_FASTDIV_EN` and N+2 with it.
- DIV started in N, `flush` in N+10 -> IDLE in N+11 with no `done`, `result` unchanged. A new MUL started in N+11 completes at N+13.
- `start` asserted while in DIV is ignored and produces no second `done`. `start` with `flush` in the same cycle -> `busy` stays 0. `reset` in N+5 of a DIV -> all outputs 0 in N+6.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV64M multiply/divide sequencer that stalls execute while it iterates.
// Optional MDU_FASTDIV_EN: divide-by-zero, signed overflow and |divisor|==1 skip the iterations.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef logic [63:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  localparam word_t MIN64 = 64'h8000_0000_0000_0000;
  localparam word_t MIN32 = 64'hFFFF_FFFF_8000_0000;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic       r_word;
  word_t      r_a;
  word_t      r_b;
  word_t      r_q;
  word_t      r_rem;
  word_t      r_dvs;
  word_t      r_result;
  logic [5:0] r_cnt;

  logic       w_accept;
  logic       w_fast;
  logic       w_ext_sgn;
  logic       w_div_sgn;
  word_t      w_pa;
  word_t      w_pb;
  word_t      w_pa_mag;
  word_t      w_pb_mag;
  word_t      w_q_init;

  assign w_accept = start && !flush && (r_state == S_IDLE);

  always_comb begin
    w_ext_sgn = !(op[2] && op[0]);
    w_div_sgn = !op[0];
    w_pa      = a;
    w_pb      = b;
    if (word) begin
      w_pa = w_ext_sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
      w_pb = w_ext_sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
    end
    w_pa_mag = (w_div_sgn && w_pa[63]) ? -w_pa : w_pa;
    w_pb_mag = (w_div_sgn && w_pb[63]) ? -w_pb : w_pb;
    // Word dividends sit in the upper half so only 32 shifts are needed.
    w_q_init = word ? {w_pa_mag[31:0], 32'b0} : w_pa_mag;
  end

`ifdef MDU_FASTDIV_EN
  logic w_in_ovf;
  assign w_in_ovf = w_div_sgn && (w_pa == (word ? MIN32 : MIN64)) && (w_pb == '1);
  assign w_fast   = op[2] && ((w_pb == '0) || w_in_ovf || (w_pb_mag == 64'd1));
`else
  assign w_fast   = 1'b0;
`endif

  // Restoring divide step
  logic [64:0] w_shift;
  logic        w_ge;
  word_t       w_sub;
  logic [5:0]  w_last;

  assign w_shift = {r_rem, r_q[63]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[63:0] - r_dvs;
  assign w_last  = r_word ? 6'd31 : 6'd63;

  // Full-width product
  logic               w_msa;
  logic               w_msb;
  logic signed [127:0] w_ma;
  logic signed [127:0] w_mb;
  logic signed [127:0] w_prod;
  word_t              w_mul_res;

  assign w_msa  = (r_op != 2'b11);
  assign w_msb  = !r_op[1];
  assign w_ma   = {{64{w_msa && r_a[63]}}, r_a};
  assign w_mb   = {{64{w_msb && r_b[63]}}, r_b};
  assign w_prod = w_ma * w_mb;

  always_comb begin
    w_mul_res = (r_op == 2'b00) ? w_prod[63:0] : w_prod[127:64];
    if (r_word) begin
      w_mul_res = {{32{w_prod[31]}}, w_prod[31:0]};
    end
  end

  // Sign fixup and special cases
  logic  w_dvd_neg;
  logic  w_dvs_neg;
  logic  w_ovf;
  word_t w_qmag;
  word_t w_rmag;
  word_t w_quo;
  word_t w_rem;
  word_t w_div_res;

  always_comb begin
    w_dvd_neg = !r_op[0] && r_a[63];
    w_dvs_neg = !r_op[0] && r_b[63];
    w_ovf     = !r_op[0] && (r_b == '1) && (r_a == (r_word ? MIN32 : MIN64));
    w_qmag    = r_q;
    w_rmag    = r_rem;
`ifdef MDU_FASTDIV_EN
    if (r_dvs == 64'd1) begin
      w_qmag = w_dvd_neg ? -r_a : r_a;
      w_rmag = '0;
    end
`endif
    w_quo = (w_dvd_neg ^ w_dvs_neg) ? -w_qmag : w_qmag;
    w_rem = w_dvd_neg ? -w_rmag : w_rmag;
    if (r_b == '0) begin
      w_quo = '1;
      w_rem = r_a;
    end else if (w_ovf) begin
      w_quo = r_a;
      w_rem = '0;
    end
    w_div_res = r_op[1] ? w_rem : w_quo;
    if (r_word) begin
      w_div_res = {{32{w_div_res[31]}}, w_div_res[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op[2])      w_next = S_MUL;
          else if (w_fast) w_next = S_FIX;
          else             w_next = S_DIV;
        end
      end
      S_MUL:   w_next = S_DONE;
      S_DIV:   if (r_cnt == w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next = S_IDLE;
    end
    busy  = (r_state != S_IDLE);
    stall = (start && (r_state == S_IDLE) && !flush) ||
            (busy && (r_state != S_DONE) && !flush);
    done  = (r_state == S_DONE) && !flush;
  end

  // Result only updates on entry to DONE, so a flush anywhere leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_word   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= op[1:0];
        r_word <= word;
        r_a    <= w_pa;
        r_b    <= w_pb;
        r_q    <= w_q_init;
        r_rem  <= '0;
        r_dvs  <= w_pb_mag;
        r_cnt  <= '0;
      end
      case (r_state)
        S_MUL: if (!flush) r_result <= w_mul_res;
        S_DIV: begin
          r_q   <= {r_q[62:0], w_ge};
          r_rem <= w_ge ? w_sub : w_shift[63:0];
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: if (!flush) r_result <= w_div_res;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, corner-case sequences and random ops
// compared against an arithmetic reference model.
module tb_muldiv_seq;

`ifdef MDU_FASTDIV_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        word;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .word   (word),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat_slow;
    int          lat_fast;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] x, input logic [63:0] y);
    logic signed [63:0]  sx, sy;
    logic signed [31:0]  sx32, sy32;
    logic [31:0]         ux32, uy32, r32;
    logic signed [127:0] sp;
    logic [127:0]        up;
    logic [63:0]         r;
    sx = x; sy = y; sx32 = x[31:0]; sy32 = y[31:0]; ux32 = x[31:0]; uy32 = y[31:0];
    r = '0; r32 = '0;
    if (w) begin
      case (o)
        3'd0: r32 = ux32 * uy32;
        3'd4: begin
          if (uy32 == 0) r32 = '1;
          else if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) r32 = ux32;
          else r32 = sx32 / sy32;
        end
        3'd5: begin
          if (uy32 == 0) r32 = '1;
          else r32 = ux32 / uy32;
        end
        3'd6: begin
          if (uy32 == 0) r32 = ux32;
          else if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) r32 = '0;
          else r32 = sx32 % sy32;
        end
        default: begin
          if (uy32 == 0) r32 = ux32;
          else r32 = ux32 % uy32;
        end
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (o)
      3'd0: r = x * y;
      3'd1: begin sp = 128'(sx) * 128'(sy); r = sp[127:64]; end
      3'd2: begin sp = 128'(sx) * $signed({64'b0, y}); r = sp[127:64]; end
      3'd3: begin up = 128'(x) * 128'(y); r = up[127:64]; end
      3'd4: begin
        if (y == 0) r = '1;
        else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
        else r = sx / sy;
      end
      3'd5: begin
        if (y == 0) r = '1;
        else r = x / y;
      end
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
        else r = sx % sy;
      end
      default: begin
        if (y == 0) r = x;
        else r = x % y;
      end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] x, input logic [63:0] y);
    bit sgn, zero, ovf, one;
    if (!o[2]) return 2;
    sgn = !o[0];
    if (w) begin
      zero = (y[31:0] == 32'd0);
      ovf  = sgn && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF;
      one  = (y[31:0] == 32'd1) || (sgn && y[31:0] == 32'hFFFF_FFFF);
    end else begin
      zero = (y == 64'd0);
      ovf  = sgn && x == 64'h8000_0000_0000_0000 && y == '1;
      one  = (y == 64'd1) || (sgn && y == '1);
    end
    if (FAST && (zero || ovf || one)) return 2;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'($urandom_range(0, 50));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called just after a falling edge; returns one cycle after DONE.
  task automatic run_op(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int exp_lat, input bit chk_stall);
    int lat;
    bit stall_bad;
    op = o; word = w; a = x; b = y; start = 1'b1;
    #1;
    if (chk_stall) check({name, ".stall_start"}, 64'(stall), 64'd1);
    lat = 0;
    stall_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (!done && !stall) stall_bad = 1'b1;
    end while (!done && lat < 200);
    check({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check({name, ".result"}, result, exp);
    if (chk_stall) begin
      check({name, ".stall_busy"}, 64'(stall_bad), 64'd0);
      check({name, ".stall_done"}, 64'(stall), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [2:0] wops [5];
    logic [2:0] ro;
    logic       rw;
    logic [63:0] ra, rb;

    wops[0] = 3'd0; wops[1] = 3'd4; wops[2] = 3'd5; wops[3] = 3'd6; wops[4] = 3'd7;

    tbl[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 2, 2};
    tbl[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2, 2};
    tbl[2]  = '{3'd0, 1'b1, 64'h8000_0000, 64'd2, 64'd0, 2, 2};
    tbl[3]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, 66};
    tbl[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66, 66};
    tbl[5]  = '{3'd7, 1'b1, 64'h1_0000_0005, 64'd3, 64'd2, 34, 34};
    tbl[6]  = '{3'd4, 1'b0, 64'd5, 64'd0, '1, 66, 2};
    tbl[7]  = '{3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 66, 2};
    tbl[8]  = '{3'd4, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 34, 2};
    tbl[9]  = '{3'd6, 1'b1, 64'h8000_0000, '1, 64'd0, 34, 2};
    tbl[10] = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h4000_0000_0000_0000, 2, 2};
    tbl[11] = '{3'd2, 1'b0, '1, '1, '1, 2, 2};
    tbl[12] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 66};
    tbl[13] = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 34, 2};
    tbl[14] = '{3'd6, 1'b1, 64'hFFFF_FFF9, 64'd2, '1, 34, 34};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; word = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset.stall", 64'(stall), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].word, tbl[i].a, tbl[i].b, tbl[i].exp,
             FAST ? tbl[i].lat_fast : tbl[i].lat_slow, 1'b1);
    end

    // Flush mid-divide: no done, result kept, MUL started right after completes in 2.
    run_op("pre_flush", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 2, 1'b0);
    op = 3'd5; word = 1'b0; a = 64'd100; b = 64'd7; start = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    check("flush.no_done", 64'(seen || done), 64'd0);
    check("flush.result", result, 64'd15);
    run_op("post_flush_mul", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 2, 1'b1);

    // Start while dividing is ignored.
    op = 3'd5; word = 1'b0; a = 64'd100; b = 64'd7; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat >= 5 && lat <= 7) begin
        start = 1'b1; op = 3'd0; a = 64'd9; b = 64'd9;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 200);
    check("busy_start.latency", 64'(lat), 64'd66);
    check("busy_start.result", result, 64'd14);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("busy_start.no_second_done", 64'(seen), 64'd0);

    // Start and flush together.
    op = 3'd0; a = 64'd2; b = 64'd2; start = 1'b1; flush = 1'b1;
    #1;
    check("start_flush.stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush.busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("start_flush.no_done", 64'(done || busy), 64'd0);

    // Reset in N+5 of a divide.
    op = 3'd4; word = 1'b0; a = 64'd1000; b = 64'd3; start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset.stall", 64'(stall), 64'd0);
    check("mid_reset.busy", 64'(busy), 64'd0);
    check("mid_reset.done", 64'(done), 64'd0);
    check("mid_reset.result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom_range(0, 1));
      ro = rw ? wops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op($sformatf("rnd%0d", i), ro, rw, ra, rb, ref_model(ro, rw, ra, rb),
             model_lat(ro, rw, ra, rb), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
